// File: rtl/proc_control.sv
// Control sequencer for the simple-processor datapath: decodes a 9-bit instruction
// and steps through T0..T3, driving bus-mux selects, load enables, addsub and done.
module proc_control (
    input  logic        clock,
    input  logic        resetn,
    input  logic        run,
    input  logic [15:0] din,
    output logic        imediate_select,
    output logic        r0_select,
    output logic        r1_select,
    output logic        r2_select,
    output logic        r3_select,
    output logic        r4_select,
    output logic        r5_select,
    output logic        r6_select,
    output logic        r7_select,
    output logic        r_select,
    output logic        ir_in,
    output logic        r0_in,
    output logic        r1_in,
    output logic        r2_in,
    output logic        r3_in,
    output logic        r4_in,
    output logic        r5_in,
    output logic        r6_in,
    output logic        r7_in,
    output logic        a_in,
    output logic        g_in,
    output logic        addsub,
    output logic        done,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    state_t      state_q;
    state_t      state_d;
    logic [8:0]  ir;
    logic [2:0]  opcode;
    logic [2:0]  rx;
    logic [2:0]  ry;
    logic [7:0]  x_dec;
    logic [7:0]  y_dec;
    logic        is_alu;

    logic [7:0]  reg_select_c;
    logic [7:0]  reg_in_c;
    logic        imediate_select_c;
    logic        r_select_c;
    logic        ir_in_c;
    logic        a_in_c;
    logic        g_in_c;
    logic        addsub_c;
    logic        done_c;

    assign opcode = ir[8:6];
    assign rx     = ir[5:3];
    assign ry     = ir[2:0];
    assign x_dec  = 8'd1 << rx;
    assign y_dec  = 8'd1 << ry;
    assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= T0;
            ir      <= 9'b0;
        end else begin
            state_q <= state_d;
            if (ir_in_c) begin
                ir <= din[15:7];
            end
        end
    end

    always_comb begin
        state_d           = state_q;
        reg_select_c      = 8'b0;
        reg_in_c          = 8'b0;
        imediate_select_c = 1'b0;
        r_select_c        = 1'b0;
        ir_in_c           = 1'b0;
        a_in_c            = 1'b0;
        g_in_c            = 1'b0;
        addsub_c          = 1'b0;
        done_c            = 1'b0;

        case (state_q)
            T0: begin
                ir_in_c = run;
                if (run) begin
                    state_d = T1;
                end
            end
            T1: begin
                case (opcode)
                    OP_MV: begin
                        reg_select_c = y_dec;
                        reg_in_c     = x_dec;
                        done_c       = 1'b1;
                        state_d      = T0;
                    end
                    OP_MVI: begin
                        imediate_select_c = 1'b1;
                        reg_in_c          = x_dec;
                        done_c            = 1'b1;
                        state_d           = T0;
                    end
                    OP_ADD, OP_SUB: begin
                        reg_select_c = x_dec;
                        a_in_c       = 1'b1;
                        state_d      = T2;
                    end
                    default: begin
                        // Reserved opcodes retire immediately without touching any register.
                        done_c  = 1'b1;
                        state_d = T0;
                    end
                endcase
            end
            T2: begin
                if (is_alu) begin
                    reg_select_c = y_dec;
                    g_in_c       = 1'b1;
                    addsub_c     = opcode[0];
                    state_d      = T3;
                end else begin
                    state_d = T0;
                end
            end
            T3: begin
                if (is_alu) begin
                    r_select_c = 1'b1;
                    reg_in_c   = x_dec;
                    done_c     = 1'b1;
                end
                state_d = T0;
            end
            default: state_d = T0;
        endcase
    end

    assign imediate_select = imediate_select_c;
    assign r_select        = r_select_c;
    assign r0_select       = reg_select_c[0];
    assign r1_select       = reg_select_c[1];
    assign r2_select       = reg_select_c[2];
    assign r3_select       = reg_select_c[3];
    assign r4_select       = reg_select_c[4];
    assign r5_select       = reg_select_c[5];
    assign r6_select       = reg_select_c[6];
    assign r7_select       = reg_select_c[7];

    assign ir_in  = ir_in_c;
    assign r0_in  = reg_in_c[0];
    assign r1_in  = reg_in_c[1];
    assign r2_in  = reg_in_c[2];
    assign r3_in  = reg_in_c[3];
    assign r4_in  = reg_in_c[4];
    assign r5_in  = reg_in_c[5];
    assign r6_in  = reg_in_c[6];
    assign r7_in  = reg_in_c[7];
    assign a_in   = a_in_c;
    assign g_in   = g_in_c;
    assign addsub = addsub_c;
    assign done   = done_c;
    assign state  = state_q;

endmodule

// File: tb/tb_proc_control.sv
// Bench for proc_control: ISA-level register model plus per-step control expectations,
// with a small bus/ALU harness driven by the DUT's control outputs.
module tb_proc_control;

    logic        clock;
    logic        resetn;
    logic        run;
    logic [15:0] din;
    logic        imediate_select, r_select, ir_in, a_in, g_in, addsub, done;
    logic        r0_select, r1_select, r2_select, r3_select, r4_select, r5_select, r6_select, r7_select;
    logic        r0_in, r1_in, r2_in, r3_in, r4_in, r5_in, r6_in, r7_in;
    logic [1:0]  state;

    int check_count = 0;
    int pass_count  = 0;

    logic [22:0] exp_q[$];

    proc_control dut (
        .clock(clock), .resetn(resetn), .run(run), .din(din),
        .imediate_select(imediate_select),
        .r0_select(r0_select), .r1_select(r1_select), .r2_select(r2_select), .r3_select(r3_select),
        .r4_select(r4_select), .r5_select(r5_select), .r6_select(r6_select), .r7_select(r7_select),
        .r_select(r_select), .ir_in(ir_in),
        .r0_in(r0_in), .r1_in(r1_in), .r2_in(r2_in), .r3_in(r3_in),
        .r4_in(r4_in), .r5_in(r5_in), .r6_in(r6_in), .r7_in(r7_in),
        .a_in(a_in), .g_in(g_in), .addsub(addsub), .done(done), .state(state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // observed control word: {selects[9:0], loads[10:0], addsub, done}
    logic [7:0]  rsel;
    logic [7:0]  rin;
    logic [9:0]  obs_sel;
    logic [10:0] obs_ld;
    logic [22:0] obs;
    assign rsel    = {r7_select, r6_select, r5_select, r4_select, r3_select, r2_select, r1_select, r0_select};
    assign rin     = {r7_in, r6_in, r5_in, r4_in, r3_in, r2_in, r1_in, r0_in};
    assign obs_sel = {imediate_select, r_select, rsel};
    assign obs_ld  = {ir_in, g_in, a_in, rin};
    assign obs     = {obs_sel, obs_ld, addsub, done};

    // datapath harness: bus mux, register file, A and G
    logic [15:0] tb_r [8] = '{default: 16'h0};
    logic [15:0] tb_a = 16'h0;
    logic [15:0] tb_g = 16'h0;
    logic [15:0] bus;

    always_comb begin
        bus = 16'h0;
        if (imediate_select) bus = din;
        else if (r_select) bus = tb_g;
        else begin
            for (int i = 0; i < 8; i++) begin
                if (rsel[i]) bus = tb_r[i];
            end
        end
    end

    always @(posedge clock) begin
        for (int i = 0; i < 8; i++) begin
            if (rin[i]) tb_r[i] <= bus;
        end
        if (a_in) tb_a <= bus;
        if (g_in) tb_g <= addsub ? (tb_a - bus) : (tb_a + bus);
    end

    // ISA-level reference register file
    logic [15:0] ref_r [8] = '{default: 16'h0};

    // at most one bus source per cycle
    always @(negedge clock) begin
        check_count++;
        if ($countones(obs_sel) > 1)
            $display("FAIL onehot_select: got sel=%03h, required at most one bit set", obs_sel);
        else
            pass_count++;
    end

    // Expected control word for step k of an instruction, from the step table.
    function automatic logic [22:0] exp_word(input logic [2:0] op, input logic [2:0] x,
                                             input logic [2:0] y, input int k);
        logic [9:0]  s;
        logic [10:0] l;
        logic        sub;
        logic        d;
        logic [7:0]  xd;
        logic [7:0]  yd;
        s = '0; l = '0; sub = 1'b0; d = 1'b0;
        xd = 8'd1 << x;
        yd = 8'd1 << y;
        case (k)
            0: l[10] = 1'b1;
            1: begin
                if (op == 3'd0) begin s[7:0] = yd; l[7:0] = xd; d = 1'b1; end
                else if (op == 3'd1) begin s[9] = 1'b1; l[7:0] = xd; d = 1'b1; end
                else if (op == 3'd2 || op == 3'd3) begin s[7:0] = xd; l[8] = 1'b1; end
                else d = 1'b1;
            end
            2: begin s[7:0] = yd; l[9] = 1'b1; sub = (op == 3'd3); end
            default: begin s[8] = 1'b1; l[7:0] = xd; d = 1'b1; end
        endcase
        return {s, l, sub, d};
    endfunction

    // driver: issue one instruction from T0 and check every step and the result
    task automatic exec_instr(input logic [15:0] instr, input logic [15:0] imm, input bit toggle_run);
        logic [2:0]  op, x, y;
        logic [22:0] e;
        int          n;
        op = instr[15:13];
        x  = instr[12:10];
        y  = instr[9:7];
        n  = (op == 3'd2 || op == 3'd3) ? 4 : 2;
        exp_q.delete();
        for (int k = 0; k < n; k++) exp_q.push_back(exp_word(op, x, y, k));
        case (op)
            3'd0: ref_r[x] = ref_r[y];
            3'd1: ref_r[x] = imm;
            3'd2: ref_r[x] = ref_r[x] + ref_r[y];
            3'd3: ref_r[x] = ref_r[x] - ref_r[y];
            default: ;
        endcase
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            if (k == 0) begin
                din = instr;
                run = 1'b1;
            end else begin
                din = (k == 1) ? imm : 16'($urandom);
                run = toggle_run ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            #1;
            e = exp_q.pop_front();
            check_count++;
            if (obs !== e)
                $display("FAIL step_ctrl: instr=%04h step=%0d got=%06h required=%06h", instr, k, obs, e);
            else
                pass_count++;
            check_count++;
            if (state !== 2'(k))
                $display("FAIL step_state: instr=%04h step=%0d got=%0d required=%0d", instr, k, state, k);
            else
                pass_count++;
        end
        @(posedge clock);
        #1;
        check_count++;
        if (tb_r[x] !== ref_r[x])
            $display("FAIL reg_result: instr=%04h R%0d got=%04h required=%04h", instr, x, tb_r[x], ref_r[x]);
        else
            pass_count++;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        run    = 1'b0;
        din    = 16'h0;
        repeat (3) @(negedge clock);
        #1;
        check_count++;
        if (obs !== 23'h0 || state !== 2'd0)
            $display("FAIL reset_idle: got ctrl=%06h state=%0d required ctrl=000000 state=0", obs, state);
        else
            pass_count++;
        run = 1'b1;
        #1;
        check_count++;
        if (obs !== {10'h0, 11'h400, 2'b00})
            $display("FAIL reset_ir_in: got ctrl=%06h required=%06h", obs, {10'h0, 11'h400, 2'b00});
        else
            pass_count++;
        run = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        #1;
        check_count++;
        if (state !== 2'd0 || obs !== 23'h0)
            $display("FAIL reset_release_idle: got state=%0d ctrl=%06h required 0/000000", state, obs);
        else
            pass_count++;
    endtask

    task automatic test_reset_abort;
        @(negedge clock);
        din = 16'h4080;
        run = 1'b1;
        @(negedge clock);
        run = 1'b0;
        @(negedge clock);
        #1;
        check_count++;
        if (state !== 2'd2 || g_in !== 1'b1)
            $display("FAIL abort_reach_t2: got state=%0d g_in=%0b required 2/1", state, g_in);
        else
            pass_count++;
        #1 resetn = 1'b0;
        #1;
        check_count++;
        if (obs !== 23'h0 || state !== 2'd0)
            $display("FAIL abort_immediate: got ctrl=%06h state=%0d required 000000/0", obs, state);
        else
            pass_count++;
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        #1;
        check_count++;
        if (obs !== 23'h0 || state !== 2'd0 || tb_r[0] !== ref_r[0])
            $display("FAIL abort_no_done: got ctrl=%06h state=%0d R0=%04h required 000000/0/%04h",
                     obs, state, tb_r[0], ref_r[0]);
        else
            pass_count++;
    endtask

    task automatic test_directed;
        exec_instr(16'h2800, 16'h00A5, 1'b0);   // mvi R2,#A5
        exec_instr(16'h1500, 16'h0000, 1'b0);   // mv R5,R2
        exec_instr(16'h2400, 16'h1234, 1'b0);   // mvi R1,#1234
        exec_instr(16'h4080, 16'h0000, 1'b0);   // add R0,R1
    endtask

    task automatic test_back_to_back;
        exec_instr(16'h2C00, 16'h0003, 1'b0);   // mvi R3,#3
        exec_instr(16'h3000, 16'h0010, 1'b0);   // mvi R4,#10
        exec_instr(16'h6E00, 16'h0000, 1'b0);   // sub R3,R4 (wraps)
        exec_instr(16'hE000, 16'hFFFF, 1'b0);   // reserved
        exec_instr(16'h4D80, 16'h0000, 1'b0);   // add R3,R3
    endtask

    task automatic test_ignored_run;
        for (int i = 0; i < 24; i++) begin
            logic [15:0] instr;
            instr = {3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 7'($urandom)};
            exec_instr(instr, 16'($urandom), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_ignored_run();
        test_reset_abort();
        for (int i = 0; i < 8; i++) begin
            check_count++;
            if (tb_r[i] !== ref_r[i])
                $display("FAIL final_reg: R%0d got=%04h required=%04h", i, tb_r[i], ref_r[i]);
            else
                pass_count++;
        end
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
